chan_config_loader: RTL and testbench
=====================================

Name: chan_config_loader

Overview:
- Downstream consumer of the SPI flash reader. Takes 32-bit channel-FPGA bitstream words from the flash reader over a valid/ready handshake.
- Configures all channel FPGAs in parallel (broadcast) using Xilinx slave-serial mode: PROG_B pulse, INIT_B wait, CCLK/DIN shifting, then DONE check.
- Reports busy, success, an error code and a word count to the control logic.

Parameters:
- NUM_CHAN, 5, number of channel FPGAs driven in broadcast.
- PROG_PULSE_CYCLES, 64, clk cycles that prog_b is held low.
- INIT_TIMEOUT, 100000, clk cycles to wait for all init_b high after the PROG_B pulse.
- DONE_TIMEOUT, 1000, CCLK rising edges allowed in FLUSH for all done to go high.

Ports:
- clk  in  1  system clock; CCLK runs at clk/2.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a configuration; ignored while busy.
- word_data  in  32  bitstream word; MSB is shifted first.
- word_valid  in  1  word_data valid.
- word_last  in  1  qualifies the final word; sampled with word_valid.
- word_ready  out  1  loader accepts a word when word_valid && word_ready.
- prog_b  out  1  active-low PROG_B, broadcast to all channels.
- init_b  in  NUM_CHAN  INIT_B from each channel; asynchronous.
- done  in  NUM_CHAN  DONE from each channel; asynchronous.
- cclk  out  1  configuration clock.
- din  out  1  serial configuration data.
- busy  out  1  high in any state other than IDLE, OK or FAIL.
- success  out  1  high in OK.
- error  out  2  0 = none, 1 = INIT timeout, 2 = INIT_B fell during shift (CRC), 3 = DONE timeout.
- words_loaded  out  24  count of accepted words; cleared on start.

Behaviour:
- Reset values:
  - prog_b=1, cclk=0, din=1, word_ready=0.
  - busy=0, success=0, error=0, words_loaded=0.
  - state=IDLE.
  - Reset mid-operation aborts immediately with these same values; no partial prog_b pulse is extended.
- Synchronisers: init_b and done each pass through a 2-flop synchroniser. Every use below refers to the synchronised value, which adds 2 cycles of latency.
- IDLE / OK / FAIL:
  - start moves the block to PROG on the next cycle.
  - On that transition: clear words_loaded, error and success.
- PROG:
  - prog_b=0 for exactly PROG_PULSE_CYCLES cycles, then go to WAIT_INIT with prog_b=1.
- WAIT_INIT:
  - When all init_b bits are 1, go to LOAD.
  - If the cycle counter reaches INIT_TIMEOUT first, go to FAIL with error=1.
- LOAD:
  - word_ready=1 (registered, asserted in the cycle the state is entered); cclk=0.
  - On word_valid: load the shift register, bitcnt=31, last_flag=word_last, words_loaded+1, go to LO; word_ready drops the next cycle.
  - No timeout while waiting in LOAD.
- LO:
  - cclk=0; din=shreg[31]; go to HI.
- HI:
  - cclk=1; din is held.
  - If bitcnt==0: go to FLUSH if last_flag, else to LOAD.
  - Otherwise: shift left, bitcnt-1, go to LO.
- Throughput: 64 clk cycles per word plus at least 1 LOAD cycle.
- During LOAD/LO/HI: if any init_b is 0, go to FAIL with error=2 on the next cycle.
- FLUSH:
  - din=1; cclk alternates 0/1 each cycle.
  - Count CCLK rising edges.
  - Once all done bits are 1, issue exactly 8 more rising edges, then go to OK.
  - If the count reaches DONE_TIMEOUT before all done bits are 1, go to FAIL with error=3.
- OK: success=1, cclk=0, din=1.
- FAIL: error holds its code, success=0, cclk=0.
- words_loaded saturates at 24'hFFFFFF.
- Simultaneous events:
  - start while busy is ignored.
  - A word presented outside LOAD is not accepted (word_ready=0).
  - In the same cycle, the error=2 check has priority over the HI→LOAD/FLUSH transition.

Test Plan:
- Normal load:
  - Stimulus: NUM_CHAN=5; start; init_b goes high 10 cycles after prog_b rises; 3 words A5A5A5A5, 00000001, FFFFFFFF (last); done goes high after 4 flush edges.
  - Required: prog_b low exactly 64 cycles; din sequence 1010... MSB-first, sampled on cclk rising edges; words_loaded=3; exactly 8 more cclk edges after done; success=1, error=0.
- INIT timeout:
  - Stimulus: INIT_TIMEOUT=200; init_b held at 0.
  - Required: FAIL exactly 200 cycles after WAIT_INIT entry; error=1; busy=0; cclk never toggles.
- CRC fail:
  - Stimulus: drive init_b[2]=0 during the second word.
  - Required: error=2 within 3 cycles of the drop (2 synchroniser + 1); word_ready stays 0; words_loaded=2.
- DONE timeout:
  - Stimulus: DONE_TIMEOUT=16; done held at 0.
  - Required: 16 cclk rising edges in FLUSH, then error=3.
- Backpressure and restart:
  - Stimulus: word_valid delayed 50 cycles in LOAD; then a second start after OK.
  - Required: cclk stays 0 while stalled; the new run pulses prog_b again and clears words_loaded.
- Mid-shift reset:
  - Stimulus: assert reset during HI.
  - Required: next cycle prog_b=1, cclk=0, din=1, word_ready=0, busy=0, state IDLE.

Source files
------------

// File: rtl/chan_config_loader.sv
// Broadcast slave-serial configuration loader for the channel FPGAs.
// It takes 32-bit bitstream words over a valid/ready handshake, pulses
// PROG_B, waits for INIT_B, shifts each word MSB-first on DIN/CCLK, and
// then clocks out flush edges until every DONE pin is high.
module chan_config_loader #(
    parameter int NUM_CHAN          = 5,
    parameter int PROG_PULSE_CYCLES = 64,
    parameter int INIT_TIMEOUT      = 100000,
    parameter int DONE_TIMEOUT      = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         word_data,
    input  logic                word_valid,
    input  logic                word_last,
    output logic                word_ready,
    output logic                prog_b,
    input  logic [NUM_CHAN-1:0] init_b,
    input  logic [NUM_CHAN-1:0] done,
    output logic                cclk,
    output logic                din,
    output logic                busy,
    output logic                success,
    output logic [1:0]          error,
    output logic [23:0]         words_loaded
);

    typedef enum logic [3:0] {
        IDLE, PROG, WAIT_INIT, LOAD, LO, HI, FLUSH, OK, FAIL
    } state_t;

    state_t state, next_state;

    logic [NUM_CHAN-1:0] init_s1, init_s2;
    logic [NUM_CHAN-1:0] done_s1, done_s2;
    logic                init_all, done_all;

    logic [31:0] cnt;
    logic [31:0] shreg;
    logic [4:0]  bitcnt;
    logic        last_flag;
    logic        done_seen;
    logic [2:0]  post_cnt;

    logic        prog_b_nxt;
    logic        cclk_nxt;
    logic [1:0]  error_nxt;

    assign init_all = &init_s2;
    assign done_all = &done_s2;

    // Two-flop synchronisers for the asynchronous INIT_B and DONE pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_s1 <= '0;
            init_s2 <= '0;
            done_s1 <= '0;
            done_s2 <= '0;
        end else begin
            init_s1 <= init_b;
            init_s2 <= init_s1;
            done_s1 <= done;
            done_s2 <= done_s1;
        end
    end

    // State register; prog_b, cclk and error are flopped here so the pins never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            prog_b <= 1'b1;
            cclk   <= 1'b0;
            error  <= 2'd0;
        end else begin
            state  <= next_state;
            prog_b <= prog_b_nxt;
            cclk   <= cclk_nxt;
            error  <= error_nxt;
        end
    end

    // Next-state logic; a low INIT_B during shifting beats every other LOAD/LO/HI exit.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, OK, FAIL: begin
                if (start) next_state = PROG;
            end
            PROG: begin
                if (cnt == 32'(PROG_PULSE_CYCLES - 1)) next_state = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (init_all)                               next_state = LOAD;
                else if (cnt == 32'(INIT_TIMEOUT - 1))      next_state = FAIL;
            end
            LOAD: begin
                if (!init_all)       next_state = FAIL;
                else if (word_valid) next_state = LO;
            end
            LO: begin
                if (!init_all) next_state = FAIL;
                else           next_state = HI;
            end
            HI: begin
                if (!init_all)          next_state = FAIL;
                else if (bitcnt == 5'd0) next_state = last_flag ? FLUSH : LOAD;
                else                    next_state = LO;
            end
            FLUSH: begin
                if (cclk) begin
                    if (done_seen) begin
                        if (post_cnt == 3'd7) next_state = OK;
                    end else if (!done_all && cnt == 32'(DONE_TIMEOUT - 1)) begin
                        next_state = FAIL;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: flopped pins are computed from the next state, status flags from the current one.
    always_comb begin
        prog_b_nxt = (next_state != PROG);
        cclk_nxt   = (next_state == HI) ||
                     (next_state == FLUSH && state == FLUSH && !cclk);
        error_nxt  = error;
        if (next_state == PROG && state != PROG) begin
            error_nxt = 2'd0;
        end else if (next_state == FAIL && state != FAIL) begin
            case (state)
                WAIT_INIT: error_nxt = 2'd1;
                FLUSH:     error_nxt = 2'd3;
                default:   error_nxt = 2'd2;
            endcase
        end
        word_ready = (state == LOAD);
        busy       = !(state == IDLE || state == OK || state == FAIL);
        success    = (state == OK);
        din        = (state == LO || state == HI) ? shreg[31] : 1'b1;
    end

    // Datapath: phase counter, shift register, bit counter, word count and flush bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            shreg        <= '0;
            bitcnt       <= '0;
            last_flag    <= 1'b0;
            done_seen    <= 1'b0;
            post_cnt     <= '0;
            words_loaded <= '0;
        end else begin
            if (next_state != state) begin
                cnt <= '0;
            end else if (state == PROG || state == WAIT_INIT || (state == FLUSH && cclk)) begin
                cnt <= cnt + 32'd1;
            end

            if (next_state == PROG && state != PROG) begin
                words_loaded <= '0;
                done_seen    <= 1'b0;
                post_cnt     <= '0;
            end else if (word_valid && word_ready && words_loaded != 24'hFFFFFF) begin
                words_loaded <= words_loaded + 24'd1;
            end

            if (state == LOAD && word_valid) begin
                shreg     <= word_data;
                bitcnt    <= 5'd31;
                last_flag <= word_last;
            end else if (state == HI && bitcnt != 5'd0) begin
                shreg  <= {shreg[30:0], 1'b0};
                bitcnt <= bitcnt - 5'd1;
            end

            if (state == FLUSH) begin
                if (done_all) done_seen <= 1'b1;
                if (done_seen && cclk) post_cnt <= post_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_chan_config_loader.sv
// Directed bench for chan_config_loader: normal load, backpressure and
// restart, mid-shift reset, INIT timeout, INIT_B drop while shifting and
// DONE timeout, each with hand-computed expectations.
module tb_chan_config_loader;

    localparam int NUM_CHAN = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [31:0]         word_data;
    logic                word_valid;
    logic                word_last;
    logic                word_ready;
    logic                prog_b;
    logic [NUM_CHAN-1:0] init_b;
    logic [NUM_CHAN-1:0] done;
    logic                cclk;
    logic                din;
    logic                busy;
    logic                success;
    logic [1:0]          error;
    logic [23:0]         words_loaded;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    int   rise_cnt  = 0;
    logic cclk_prev = 1'b0;
    logic din_log[$];

    chan_config_loader #(
        .NUM_CHAN          (NUM_CHAN),
        .PROG_PULSE_CYCLES (64),
        .INIT_TIMEOUT      (200),
        .DONE_TIMEOUT      (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_last    (word_last),
        .word_ready   (word_ready),
        .prog_b       (prog_b),
        .init_b       (init_b),
        .done         (done),
        .cclk         (cclk),
        .din          (din),
        .busy         (busy),
        .success      (success),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    // Record DIN at every CCLK rising edge, sampled on the falling clk edge.
    always @(negedge clk) begin
        if (cclk === 1'b1 && cclk_prev === 1'b0) begin
            din_log.push_back(din);
            rise_cnt++;
        end
        cclk_prev = cclk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
            $error("[TB] %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts cycles with prog_b low, starting from the current cycle.
    task automatic measure_prog(output int n);
        n = 0;
        while (prog_b === 1'b0 && n < 1000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (word_ready !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        check_output(tag, 32'(word_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] data, input logic last, input string tag);
        logic ok = 1'b0;
        word_data  = data;
        word_last  = last;
        word_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (word_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        word_last  = 1'b0;
        check_output(tag, 32'(ok), 32'd1);
    endtask

    function automatic logic [31:0] get_word(input int base);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            if (base + i < din_log.size()) w = {w[30:0], din_log[base + i]};
            else                           w = {w[30:0], 1'bx};
        end
        return w;
    endfunction

    task automatic check_quiet(input string tag);
        check_output({tag, "_prog_b"},     32'(prog_b),       32'd1);
        check_output({tag, "_cclk"},       32'(cclk),         32'd0);
        check_output({tag, "_din"},        32'(din),          32'd1);
        check_output({tag, "_word_ready"}, 32'(word_ready),   32'd0);
        check_output({tag, "_busy"},       32'(busy),         32'd0);
        check_output({tag, "_success"},    32'(success),      32'd0);
        check_output({tag, "_error"},      32'(error),        32'd0);
        check_output({tag, "_words"},      32'(words_loaded), 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int base_rise;
        int base_din;

        reset      = 1'b1;
        start      = 1'b0;
        word_data  = '0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        init_b     = '0;
        done       = '0;
        tick(3);
        check_quiet("reset");
        reset = 1'b0;
        tick(1);

        // Normal load: three words, DONE after four flush edges.
        $display("[TB] normal load");
        pulse_start();
        check_output("norm_busy", 32'(busy), 32'd1);
        measure_prog(n);
        check_output("norm_prog_low_cycles", 32'(n), 32'd64);
        tick(10);
        init_b    = '1;
        base_rise = rise_cnt;
        base_din  = din_log.size();
        send_word(32'hA5A5A5A5, 1'b0, "norm_accept0");
        send_word(32'h00000001, 1'b0, "norm_accept1");
        send_word(32'hFFFFFFFF, 1'b1, "norm_accept2");
        n = 0;
        while (rise_cnt - base_rise < 100 && n < 500) begin
            tick(1);
            n++;
        end
        check_output("norm_flush4_reached", 32'(rise_cnt - base_rise), 32'd100);
        done = '1;
        m    = rise_cnt;
        n    = 0;
        while (success !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_output("norm_success", 32'(success), 32'd1);
        // One edge falls inside the 2-cycle synchroniser window, then exactly 8 more.
        check_output("norm_edges_after_done", 32'(rise_cnt - m), 32'd9);
        check_output("norm_error", 32'(error), 32'd0);
        check_output("norm_busy_end", 32'(busy), 32'd0);
        check_output("norm_words", 32'(words_loaded), 32'd3);
        check_output("norm_cclk_ok", 32'(cclk), 32'd0);
        check_output("norm_din_ok", 32'(din), 32'd1);
        check_output("norm_din_w0", get_word(base_din), 32'hA5A5A5A5);
        check_output("norm_din_w1", get_word(base_din + 32), 32'h00000001);
        check_output("norm_din_w2", get_word(base_din + 64), 32'hFFFFFFFF);

        // Backpressure and restart from OK; DONE is already high.
        $display("[TB] backpressure and restart");
        pulse_start();
        check_output("bp_words_cleared", 32'(words_loaded), 32'd0);
        check_output("bp_success_cleared", 32'(success), 32'd0);
        check_output("bp_prog_low", 32'(prog_b), 32'd0);
        measure_prog(n);
        check_output("bp_prog_low_cycles", 32'(n), 32'd64);
        wait_ready("bp_ready");
        base_rise = rise_cnt;
        base_din  = din_log.size();
        tick(50);
        check_output("bp_stall_no_edges", 32'(rise_cnt - base_rise), 32'd0);
        check_output("bp_stall_cclk", 32'(cclk), 32'd0);
        check_output("bp_stall_ready", 32'(word_ready), 32'd1);
        send_word(32'h80000001, 1'b1, "bp_accept");
        n = 0;
        while (success !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check_output("bp_success", 32'(success), 32'd1);
        check_output("bp_total_edges", 32'(rise_cnt - base_rise), 32'd40);
        check_output("bp_words", 32'(words_loaded), 32'd1);
        check_output("bp_din_w0", get_word(base_din), 32'h80000001);

        // Reset while CCLK is high in the middle of a word.
        $display("[TB] mid-shift reset");
        pulse_start();
        measure_prog(n);
        wait_ready("msr_ready");
        send_word(32'h0F0F0F0F, 1'b0, "msr_accept");
        n = 0;
        while (cclk !== 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        check_output("msr_in_hi", 32'(cclk), 32'd1);
        reset = 1'b1;
        tick(1);
        check_quiet("msr");
        reset = 1'b0;
        tick(1);

        // INIT timeout, with a start pulse ignored while busy.
        $display("[TB] init timeout");
        init_b    = '0;
        done      = '0;
        base_rise = rise_cnt;
        pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        measure_prog(n);
        check_output("it_prog_low_cycles", 32'(n + 1), 32'd64);
        m = 0;
        while (error === 2'd0 && m < 1000) begin
            tick(1);
            m++;
        end
        check_output("it_cycles_to_fail", 32'(m), 32'd200);
        check_output("it_error", 32'(error), 32'd1);
        check_output("it_busy", 32'(busy), 32'd0);
        check_output("it_success", 32'(success), 32'd0);
        check_output("it_no_cclk", 32'(rise_cnt - base_rise), 32'd0);

        // INIT_B[2] drops while the second word is shifting.
        $display("[TB] init_b drop during shift");
        init_b = '1;
        tick(3);
        pulse_start();
        check_output("crc_error_cleared", 32'(error), 32'd0);
        measure_prog(n);
        base_din = din_log.size();
        send_word(32'h3C3C3C3C, 1'b0, "crc_accept0");
        send_word(32'hC3C3C3C3, 1'b0, "crc_accept1");
        check_output("crc_words_mid", 32'(words_loaded), 32'd2);
        tick(10);
        init_b[2] = 1'b0;
        tick(2);
        check_output("crc_error_not_yet", 32'(error), 32'd0);
        check_output("crc_busy_not_yet", 32'(busy), 32'd1);
        tick(1);
        check_output("crc_error", 32'(error), 32'd2);
        check_output("crc_busy", 32'(busy), 32'd0);
        check_output("crc_ready", 32'(word_ready), 32'd0);
        check_output("crc_din_w0", get_word(base_din), 32'h3C3C3C3C);
        word_data  = 32'hDEADBEEF;
        word_valid = 1'b1;
        tick(5);
        check_output("crc_ready_held", 32'(word_ready), 32'd0);
        check_output("crc_words", 32'(words_loaded), 32'd2);
        word_valid = 1'b0;

        // DONE never rises: 16 flush edges then error 3.
        $display("[TB] done timeout");
        init_b = '1;
        done   = '0;
        tick(3);
        pulse_start();
        check_output("dt_error_cleared", 32'(error), 32'd0);
        measure_prog(n);
        base_rise = rise_cnt;
        base_din  = din_log.size();
        send_word(32'h12345678, 1'b1, "dt_accept");
        n = 0;
        while (error === 2'd0 && n < 300) begin
            tick(1);
            n++;
        end
        check_output("dt_error", 32'(error), 32'd3);
        check_output("dt_edges", 32'(rise_cnt - base_rise), 32'd48);
        check_output("dt_success", 32'(success), 32'd0);
        check_output("dt_busy", 32'(busy), 32'd0);
        check_output("dt_cclk", 32'(cclk), 32'd0);
        check_output("dt_din_w0", get_word(base_din), 32'h12345678);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
